// File: rtl/cv32e40p_pkg.sv
// Shared fault-tolerance constants and types for the cv32e40p FT blocks.
package cv32e40p_pkg;

  localparam int unsigned FT_REPLICAS    = 3;
  localparam int unsigned PIPE_ERR_CNT_W = 8;

  typedef struct packed {
    logic                      err;
    logic [PIPE_ERR_CNT_W-1:0] cnt;
  } pipe_err_t;

endpackage

// File: rtl/cv32e40p_ft_voter.sv
// Three-input bitwise majority voter with a replica-mismatch flag.
module cv32e40p_ft_voter #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] maj_o,
  output logic         mismatch_o
);

  assign maj_o      = (a_i & b_i) | (b_i & c_i) | (a_i & c_i);
  assign mismatch_o = |((a_i ^ b_i) | (b_i ^ c_i));

endmodule

// File: rtl/cv32e40p_ft_pipe_reg.sv
// Inter-stage pipeline register with grouped payload, partial update and optional TMR.
module cv32e40p_ft_pipe_reg
  import cv32e40p_pkg::*;
#(
  parameter int unsigned        N_GROUPS  = 4,
  parameter int unsigned        GROUP_W   = 32,
  parameter int unsigned        CTRL_W    = 16,
  parameter logic [CTRL_W-1:0]  CTRL_RST  = '0,
  parameter bit                 TMR_EN    = 1'b1,
  parameter int unsigned        ERR_CNT_W = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              valid_i,
  output logic                              ready_o,
  input  logic [CTRL_W-1:0]                 ctrl_i,
  input  logic [N_GROUPS*GROUP_W-1:0]       data_i,
  input  logic [N_GROUPS-1:0]               grp_en_i,
  input  logic                              flush_i,
  input  logic                              upd_i,
  input  logic [N_GROUPS-1:0]               upd_mask_i,
  input  logic [N_GROUPS*GROUP_W-1:0]       upd_data_i,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [CTRL_W-1:0]                 ctrl_o,
  output logic [N_GROUPS*GROUP_W-1:0]       data_o,
  input  logic [2:0]                        inj_i,
  input  logic [CTRL_W+N_GROUPS*GROUP_W:0]  inj_mask_i,
  output logic                              err_o,
  output logic [ERR_CNT_W-1:0]              err_cnt_o
);

  localparam int unsigned DATA_W = N_GROUPS * GROUP_W;
  localparam int unsigned S_W    = 1 + CTRL_W + DATA_W;
  localparam int unsigned N_REP  = TMR_EN ? FT_REPLICAS : 1;

  localparam logic [S_W-1:0] S_RST = {1'b0, CTRL_RST, {DATA_W{1'b0}}};

  logic [S_W-1:0]       rep_q [N_REP];
  logic [S_W-1:0]       rep_d [N_REP];
  logic [S_W-1:0]       s_vote;
  logic [S_W-1:0]       s_d;
  logic                 mismatch;
  logic [2:0]           inj_sel;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic [ERR_CNT_W-1:0] err_cnt_d;

  generate
    if (TMR_EN) begin : g_tmr
      cv32e40p_ft_voter #(
        .W (S_W)
      ) u_voter (
        .a_i        (rep_q[0]),
        .b_i        (rep_q[1]),
        .c_i        (rep_q[2]),
        .maj_o      (s_vote),
        .mismatch_o (mismatch)
      );
      assign inj_sel = inj_i;
    end else begin : g_single
      assign s_vote   = rep_q[0];
      assign mismatch = 1'b0;
      assign inj_sel  = {2'b00, |inj_i};
    end
  endgenerate

  assign valid_o = s_vote[S_W-1];
  assign ctrl_o  = s_vote[DATA_W +: CTRL_W];
  assign data_o  = s_vote[DATA_W-1:0];
  assign ready_o = ~upd_i & (flush_i | ready_i | ~valid_o);
  assign err_o   = mismatch;

  // Next state is built from the voted value, so hold cycles scrub every replica.
  always_comb begin
    s_d = s_vote;
    if (flush_i) begin
      s_d[S_W-1]              = 1'b0;
      s_d[DATA_W +: CTRL_W]   = CTRL_RST;
    end else if (upd_i && valid_o) begin
      for (int unsigned g = 0; g < N_GROUPS; g++) begin
        if (upd_mask_i[g]) begin
          s_d[g*GROUP_W +: GROUP_W] = upd_data_i[g*GROUP_W +: GROUP_W];
        end
      end
    end else if (valid_i && ready_o) begin
      s_d[S_W-1]            = 1'b1;
      s_d[DATA_W +: CTRL_W] = ctrl_i;
      for (int unsigned g = 0; g < N_GROUPS; g++) begin
        if (grp_en_i[g]) begin
          s_d[g*GROUP_W +: GROUP_W] = data_i[g*GROUP_W +: GROUP_W];
        end
      end
    end else if (ready_i && !valid_i) begin
      s_d[S_W-1]            = 1'b0;
      s_d[DATA_W +: CTRL_W] = CTRL_RST;
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < N_REP; r++) begin
      rep_d[r] = inj_sel[r] ? (s_d ^ inj_mask_i) : s_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned r = 0; r < N_REP; r++) begin
      if (rst) begin
        rep_q[r] <= S_RST;
      end else begin
        rep_q[r] <= rep_d[r];
      end
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_o && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_cv32e40p_ft_pipe_reg.sv
// Directed self-checking bench for cv32e40p_ft_pipe_reg with default parameters.
module tb_cv32e40p_ft_pipe_reg;

  logic         clk;
  logic         rst;
  logic         valid_i;
  logic         ready_o;
  logic [15:0]  ctrl_i;
  logic [127:0] data_i;
  logic [3:0]   grp_en_i;
  logic         flush_i;
  logic         upd_i;
  logic [3:0]   upd_mask_i;
  logic [127:0] upd_data_i;
  logic         valid_o;
  logic         ready_i;
  logic [15:0]  ctrl_o;
  logic [127:0] data_o;
  logic [2:0]   inj_i;
  logic [144:0] inj_mask_i;
  logic         err_o;
  logic [7:0]   err_cnt_o;

  int nCompared;
  int nMismatched;

  cv32e40p_ft_pipe_reg dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .ctrl_i     (ctrl_i),
    .data_i     (data_i),
    .grp_en_i   (grp_en_i),
    .flush_i    (flush_i),
    .upd_i      (upd_i),
    .upd_mask_i (upd_mask_i),
    .upd_data_i (upd_data_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .ctrl_o     (ctrl_o),
    .data_o     (data_o),
    .inj_i      (inj_i),
    .inj_mask_i (inj_mask_i),
    .err_o      (err_o),
    .err_cnt_o  (err_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b1; ctrl_i = 16'h00F0; data_i = {4{32'hFFFF0000}};
    grp_en_i = 4'hF; flush_i = 1'b0; upd_i = 1'b0; upd_mask_i = 4'h0;
    upd_data_i = '0; ready_i = 1'b0; inj_i = 3'b000; inj_mask_i = '0;
    tick(); tick();
    nCompared++; if (valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_valid got %b want 0", valid_o); end
    nCompared++; if (data_o !== 128'h0) begin nMismatched++; $display("[TB] FAIL reset_data got %h want 0", data_o); end
    nCompared++; if (ctrl_o !== 16'h0) begin nMismatched++; $display("[TB] FAIL reset_ctrl got %h want 0", ctrl_o); end
    nCompared++; if (err_cnt_o !== 8'd0) begin nMismatched++; $display("[TB] FAIL reset_errcnt got %0d want 0", err_cnt_o); end
    valid_i = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_masked_load();
    valid_i = 1'b1; ctrl_i = 16'h1234; grp_en_i = 4'b0101; data_i = {4{32'hA5A5A5A5}};
    #1;
    nCompared++; if (ready_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL load_ready got %b want 1", ready_o); end
    tick();
    valid_i = 1'b0;
    nCompared++; if (data_o !== {32'h0, 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5}) begin nMismatched++; $display("[TB] FAIL load_data got %h want 00000000a5a5a5a500000000a5a5a5a5", data_o); end
    nCompared++; if (valid_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL load_valid got %b want 1", valid_o); end
    nCompared++; if (ctrl_o !== 16'h1234) begin nMismatched++; $display("[TB] FAIL load_ctrl got %h want 1234", ctrl_o); end
  endtask

  task automatic test_backpressure_bubble();
    logic [127:0] expData;
    expData = {32'h0, 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5};
    ready_i = 1'b0; valid_i = 1'b1; ctrl_i = 16'h9999; data_i = {4{32'h12345678}}; grp_en_i = 4'hF;
    #1;
    nCompared++; if (ready_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL bp_ready got %b want 0", ready_o); end
    for (int i = 0; i < 5; i++) begin
      tick();
      nCompared++;
      if (valid_o !== 1'b1 || ctrl_o !== 16'h1234 || data_o !== expData) begin
        nMismatched++;
        $display("[TB] FAIL bp_stable cyc %0d got v=%b c=%h d=%h want v=1 c=1234 d=%h", i, valid_o, ctrl_o, data_o, expData);
      end
    end
    ready_i = 1'b1; valid_i = 1'b0;
    tick();
    nCompared++; if (valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL bubble_valid got %b want 0", valid_o); end
    nCompared++; if (ctrl_o !== 16'h0) begin nMismatched++; $display("[TB] FAIL bubble_ctrl got %h want 0", ctrl_o); end
    nCompared++; if (data_o !== expData) begin nMismatched++; $display("[TB] FAIL bubble_data got %h want %h", data_o, expData); end
  endtask

  task automatic test_partial_update();
    ready_i = 1'b0; valid_i = 1'b1; ctrl_i = 16'h00AB; grp_en_i = 4'hF;
    data_i = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    tick();
    upd_i = 1'b1; upd_mask_i = 4'b0010;
    upd_data_i = {32'hDEAD0003, 32'hDEAD0002, 32'h00000004, 32'hDEAD0000};
    valid_i = 1'b1; ctrl_i = 16'hFFFF; data_i = {4{32'h77777777}};
    #1;
    nCompared++; if (ready_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL upd_ready got %b want 0", ready_o); end
    tick();
    upd_i = 1'b0; valid_i = 1'b0;
    nCompared++; if (data_o !== {32'h44444444, 32'h33333333, 32'h00000004, 32'h11111111}) begin nMismatched++; $display("[TB] FAIL upd_data got %h want 44444444333333330000000411111111", data_o); end
    nCompared++; if (ctrl_o !== 16'h00AB) begin nMismatched++; $display("[TB] FAIL upd_ctrl got %h want 00ab", ctrl_o); end
    nCompared++; if (valid_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL upd_valid got %b want 1", valid_o); end
  endtask

  task automatic test_flush_vs_load();
    logic [127:0] expData;
    expData = {32'h44444444, 32'h33333333, 32'h00000004, 32'h11111111};
    flush_i = 1'b1; valid_i = 1'b1; ready_i = 1'b0; ctrl_i = 16'h0007; data_i = {4{32'hBBBBBBBB}};
    #1;
    nCompared++; if (ready_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL flush_ready got %b want 1", ready_o); end
    tick();
    valid_i = 1'b0;
    nCompared++; if (valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_valid got %b want 0", valid_o); end
    nCompared++; if (ctrl_o !== 16'h0) begin nMismatched++; $display("[TB] FAIL flush_ctrl got %h want 0", ctrl_o); end
    nCompared++; if (data_o !== expData) begin nMismatched++; $display("[TB] FAIL flush_data got %h want %h", data_o, expData); end
    upd_i = 1'b1; upd_mask_i = 4'hF; upd_data_i = {4{32'hFFFFFFFF}};
    #1;
    nCompared++; if (ready_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_upd_ready got %b want 0", ready_o); end
    tick();
    flush_i = 1'b0;
    tick();
    upd_i = 1'b0;
    nCompared++; if (data_o !== expData || valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL upd_noop got v=%b d=%h want v=0 d=%h", valid_o, data_o, expData); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] expData;
    ready_i = 1'b1; valid_i = 1'b1; grp_en_i = 4'hF;
    for (int i = 1; i <= 4; i++) begin
      expData = {4{32'(i) * 32'h01010101}};
      data_i = expData; ctrl_i = 16'(i);
      tick();
      nCompared++;
      if (valid_o !== 1'b1 || ctrl_o !== 16'(i) || data_o !== expData) begin
        nMismatched++;
        $display("[TB] FAIL b2b_%0d got v=%b c=%h d=%h want v=1 c=%h d=%h", i, valid_o, ctrl_o, data_o, 16'(i), expData);
      end
    end
    valid_i = 1'b0;
    tick();
    nCompared++; if (valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL b2b_drain got %b want 0", valid_o); end
  endtask

  task automatic test_tmr();
    valid_i = 1'b1; ready_i = 1'b0; ctrl_i = 16'h0055; grp_en_i = 4'hF; data_i = '0;
    tick();
    valid_i = 1'b0;
    nCompared++; if (err_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL tmr_noerr got %b want 0", err_o); end
    inj_i = 3'b010; inj_mask_i = 145'd1 << 5;
    tick();
    inj_i = 3'b000;
    nCompared++; if (err_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL single_err got %b want 1", err_o); end
    nCompared++; if (data_o !== 128'h0) begin nMismatched++; $display("[TB] FAIL single_data got %h want 0", data_o); end
    tick();
    nCompared++; if (err_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_scrub got %b want 0", err_o); end
    nCompared++; if (err_cnt_o !== 8'd1) begin nMismatched++; $display("[TB] FAIL single_cnt got %0d want 1", err_cnt_o); end
    inj_i = 3'b011;
    tick();
    inj_i = 3'b000;
    nCompared++; if (data_o !== 128'h20) begin nMismatched++; $display("[TB] FAIL double_data got %h want 20", data_o); end
    nCompared++; if (err_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL double_err got %b want 1", err_o); end
    tick();
    nCompared++; if (err_cnt_o !== 8'd2) begin nMismatched++; $display("[TB] FAIL double_cnt got %0d want 2", err_cnt_o); end
    nCompared++; if (data_o !== 128'h20 || ctrl_o !== 16'h0055) begin nMismatched++; $display("[TB] FAIL double_hold got c=%h d=%h want c=0055 d=20", ctrl_o, data_o); end
  endtask

  task automatic test_saturation();
    inj_i = 3'b001; inj_mask_i = 145'd1;
    for (int i = 0; i < 300; i++) tick();
    inj_i = 3'b000;
    tick(); tick();
    nCompared++; if (err_cnt_o !== 8'd255) begin nMismatched++; $display("[TB] FAIL sat_cnt got %0d want 255", err_cnt_o); end
    nCompared++; if (data_o !== 128'h20 || err_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL sat_data got e=%b d=%h want e=0 d=20", err_o, data_o); end
    rst = 1'b1; inj_i = 3'b111; inj_mask_i = '1;
    tick();
    rst = 1'b0; inj_i = 3'b000; inj_mask_i = '0;
    nCompared++; if (err_cnt_o !== 8'd0 || err_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_inj got cnt=%0d e=%b want cnt=0 e=0", err_cnt_o, err_o); end
    nCompared++; if (valid_o !== 1'b0 || data_o !== 128'h0) begin nMismatched++; $display("[TB] FAIL rst_inj_state got v=%b d=%h want v=0 d=0", valid_o, data_o); end
  endtask

  initial begin
    nCompared = 0;
    nMismatched = 0;
    test_reset();
    test_masked_load();
    test_backpressure_bubble();
    test_partial_update();
    test_flush_vs_load();
    test_back_to_back();
    test_tmr();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/cv32e40p_ft_pipe_reg.md
Name: cv32e40p_ft_pipe_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the fault-tolerant cv32e40p core, for use at the ID/EX, EX/WB and similar stage boundaries.
- Carries a control word and a payload split into N_GROUPS independently-enabled field groups, with a valid/ready handshake, flush, and masked in-place partial update (a generalisation of the misaligned-access operand rewrite).
- State is optionally triplicated (TMR), with a bitwise majority vote, per-cycle scrubbing and error reporting.

Parameters:
- N_GROUPS, 4, number of independently loadable payload groups
- GROUP_W, 32, width of each payload group in bits
- CTRL_W, 16, width of the control word (write enables, op codes, branch flag)
- CTRL_RST, '0, control word value on reset, flush and bubble
- TMR_EN, 1, 1 = three replicas with majority vote; 0 = single copy
- ERR_CNT_W, 8, width of the saturating error counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_i  in  1  upstream stage has a new entry
- ready_o  out  1  register can accept an entry this cycle
- ctrl_i  in  CTRL_W  incoming control word
- data_i  in  N_GROUPS*GROUP_W  incoming payload; group g = bits [g*GROUP_W +: GROUP_W]
- grp_en_i  in  N_GROUPS  per-group load enable for an accepted entry
- flush_i  in  1  squash the current and incoming entry
- upd_i  in  1  in-place partial update of the held entry
- upd_mask_i  in  N_GROUPS  groups overwritten by upd_i
- upd_data_i  in  N_GROUPS*GROUP_W  partial-update data
- valid_o  out  1  held entry is valid
- ready_i  in  1  downstream stage consumes the entry
- ctrl_o  out  CTRL_W  voted control word
- data_o  out  N_GROUPS*GROUP_W  voted payload
- inj_i  in  3  one-hot replica select for fault injection (verification only; tied to 0 in synthesis)
- inj_mask_i  in  1+CTRL_W+N_GROUPS*GROUP_W  XOR mask applied to the selected replica; bit order {valid, ctrl, data}
- err_o  out  1  replica mismatch present this cycle
- err_cnt_o  out  ERR_CNT_W  saturating count of cycles with err_o = 1

Behaviour:
- Single clock domain. Reset is synchronous and active-high on rst. Reset overrides every other event, including injection.
- Reset values, all replicas: valid = 0, ctrl = CTRL_RST, data = 0, err_cnt = 0.
- ready_o = ~upd_i & (flush_i | ready_i | ~valid_o). This is combinational; there is no path from ready_o back to valid_i.
- Stored state S = {valid, ctrl, data}. Next-state priority, highest first:
  1. rst: load reset values.
  2. flush_i: valid = 0, ctrl = CTRL_RST, data held. An input accepted in the same cycle is discarded.
  3. upd_i & valid_o: each group g with upd_mask_i[g] = 1 loads upd_data_i group g; valid and ctrl are held.
  4. valid_i & ready_o (load): valid = 1, ctrl = ctrl_i, group g loads data_i only if grp_en_i[g] = 1, otherwise it holds.
  5. ready_i & ~valid_i (bubble): valid = 0, ctrl = CTRL_RST, data held.
  6. Otherwise: hold. Under ready_i = 0 and valid_o = 1 the outputs are stable.
- upd_i while valid_o = 0 is a no-op.
- Latency is one cycle from an accepted input to valid_o. Sustained throughput is one entry per cycle while ready_i = 1.
- TMR_EN = 1:
  - The three replicas R0..R2 all receive the same next state.
  - The outputs are the bitwise majority maj(R0, R1, R2).
  - In a hold cycle every replica is rewritten with the voted value (scrubbing).
  - Injection XORs inj_mask_i into the next state of each replica selected by inj_i. It is applied after the priority mux, so the corruption is visible the following cycle.
- err_o = OR over bits of (R0^R1 | R1^R2), combinational on the stored replicas. A single-replica upset therefore raises err_o for exactly one cycle; the next edge scrubs or reloads it.
- A two-replica upset of the same bit corrupts the output silently, apart from err_o = 1. This is a documented limit of the scheme.
- err_cnt_o increments by 1 on each clock edge where err_o = 1, saturating at all-ones. Only rst clears it.
- TMR_EN = 0: single copy; err_o = 0; err_cnt_o stays 0; injection XORs into the single copy.
- Simultaneous flush_i and upd_i: flush wins and ready_o = 0.

Decomposition:
- cv32e40p_pkg gets a FT_REPLICAS = 3 constant and a pipe_err_t struct {err, cnt}.
- One sub-module, cv32e40p_ft_voter: parametrised width, three inputs, majority output plus mismatch flag. It is instantiated once over S and is reusable by other FT blocks.

Test Plan:
- Reset: assert rst for 2 cycles with valid_i = 1 → valid_o = 0, data_o = 0, ctrl_o = CTRL_RST, err_cnt_o = 0.
- Masked load: hold data = 0, then load valid_i = 1, grp_en_i = 4'b0101, data_i = {4{32'hA5A5A5A5}} → next cycle groups 0 and 2 = A5A5A5A5, groups 1 and 3 = 0, valid_o = 1.
- Backpressure then bubble:
  - ready_i = 0 with valid_o = 1 → ready_o = 0, outputs stable for 5 cycles.
  - Then ready_i = 1, valid_i = 0 → valid_o = 0, ctrl_o = CTRL_RST, data_o unchanged.
- Partial update: valid_o = 1, upd_i = 1, upd_mask_i = 4'b0010, upd_data_i group 1 = 32'h4, valid_i = 1 → ready_o = 0, only group 1 becomes 0x4, ctrl_o and valid_o held.
- Flush vs load: flush_i = 1 together with valid_i = 1, ready_i = 0 → ready_o = 1, next cycle valid_o = 0, ctrl_o = CTRL_RST.
- TMR:
  - inj_i = 3'b010 with data bit 5 flipped → data_o unchanged, err_o = 1 for one cycle, err_cnt_o = 1.
  - inj_i = 3'b011 on the same bit → data_o bit 5 flips, err_o = 1, err_cnt_o = 2.
  - 300 single upsets → err_cnt_o saturates at 255.
